posit_add_arbiter: RTL and testbench
====================================

POSIT_ADD_ARBITER -- requirements
Module: posit_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one 4-stage posit adder (2..8).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from adder start to adder done.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester operation request.
REQ-006 SHALL have port req_in1  in  32*NREQ  operand A, requester i at bits [32i+31:32i].
REQ-007 SHALL have port req_in2  in  32*NREQ  operand B, same packing.
REQ-008 SHALL have port req_ready  out  NREQ  one-hot grant; operation accepted when req_valid[i] & req_ready[i].
REQ-009 SHALL have port hold  in  1  drain request; blocks new grants.
REQ-010 SHALL have port add_start, add_in1, add_in2  out  1/32/32  registered drive to shared adder.
REQ-011 SHALL have port add_result, add_inf, add_zero, add_done  in  32/1/1/1  adder outputs.
REQ-012 SHALL have port rsp_valid  out  NREQ  one-hot result strobe to owning requester.
REQ-013 SHALL have port rsp_result, rsp_inf, rsp_zero  out  32/1/1  pass-through of adder outputs.
REQ-014 SHALL have port inflight  out  4  count of accepted, unreturned operations.
REQ-015 SHALL have port idle  out  1  hold high and inflight zero.
REQ-016 SHALL have port err_sync  out  1  sticky tag/done mismatch flag.

Function
REQ-017 SHALL grant at most one requester per cycle, round-robin: search starts at pointer ptr, first i with req_valid[i] wins.
REQ-018 SHALL update ptr to (grant+1) mod NREQ after a grant; ptr unchanged without grant.
REQ-019 SHALL drive req_ready combinationally from req_valid, ptr and hold; all zero when hold=1.
REQ-020 SHALL register granted operands onto add_in1/add_in2 with add_start=1 the cycle after grant; add_in1/add_in2 = 0 when add_start=0.
REQ-021 SHALL, on each add_start, push {valid=1, id} into a LATENCY-deep tag shift register; push {0, x} otherwise; shift every cycle.
REQ-022 SHALL assert rsp_valid[id] for exactly one cycle when tag output valid=1 (LATENCY cycles after add_start, grant-to-rsp = LATENCY+1 cycles).
REQ-023 SHALL keep rsp_valid zero when tag output valid=0, regardless of add_done.
REQ-024 SHALL set err_sync when add_done != tag output valid; err_sync SHALL be cleared only by reset.
REQ-025 SHALL increment inflight on grant, decrement on rsp, hold value on both same cycle; max LATENCY+1, never wrap.
REQ-026 SHALL sustain back-to-back grants every cycle (full throughput, no bubbles).
REQ-027 SHALL let operations in flight complete normally while hold=1; idle=1 once inflight=0.
REQ-028 SHALL provide no backpressure on responses; requesters accept rsp unconditionally.
REQ-029 SHALL return responses in issue order.

Reset
REQ-030 SHALL, while rst_n=0, force req_ready=0, add_start=0, add_in1/add_in2=0, rsp_valid=0, all tag valids=0, ptr=0, inflight=0, err_sync=0.
REQ-031 SHALL drop in-flight operations on reset mid-operation; no rsp_valid for them after release, and add_done from pre-reset pipeline contents SHALL NOT set err_sync in the first LATENCY cycles after release.
REQ-032 SHALL accept requests in the first cycle after rst_n deasserts.

Verification
REQ-033 Single: req_valid=0001, in1=0x40000000 (1.0), in2=0x40000000 -> req_ready=0001 at T, add_start at T+1, rsp_valid=0001 at T+5, rsp_result=0x48000000 (2.0).
REQ-034 Fairness: req_valid=1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid same order, 1 per cycle, inflight saturates at 5.
REQ-035 Hold/drain: all requesting, hold=1 at cycle 3 -> no grants from cycle 3; three rsp strobes follow; idle=1 when inflight=0.
REQ-036 Reset mid-flight: 3 ops issued, rst_n low 1 cycle -> no rsp_valid afterwards, inflight=0, err_sync=0, ptr=0.
REQ-037 Mismatch: stub adder drives add_done=1 with no tag valid -> err_sync=1 next cycle, stays 1 until reset, rsp_valid stays 0.
REQ-038 Zero/inf: in1=0x80000000 (NaR), in2=0x40000000 -> rsp_inf=1, rsp_result=0x80000000 to correct requester.

Source files
------------

// File: rtl/posit_add_arbiter_if.sv
// Requester / shared-adder / response bundle for posit_add_arbiter.
// slave = arbiter side, master = requesters plus adder side.
interface posit_add_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_in1;
  logic [32*NREQ-1:0] req_in2;
  logic [NREQ-1:0]    req_ready;
  logic               hold;

  logic               add_start;
  logic [31:0]        add_in1;
  logic [31:0]        add_in2;
  logic [31:0]        add_result;
  logic               add_inf;
  logic               add_zero;
  logic               add_done;

  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_result;
  logic               rsp_inf;
  logic               rsp_zero;

  modport slave (
    input  req_valid, req_in1, req_in2, hold,
    input  add_result, add_inf, add_zero, add_done,
    output req_ready,
    output add_start, add_in1, add_in2,
    output rsp_valid, rsp_result, rsp_inf, rsp_zero
  );

  modport master (
    output req_valid, req_in1, req_in2, hold,
    output add_result, add_inf, add_zero, add_done,
    input  req_ready,
    input  add_start, add_in1, add_in2,
    input  rsp_valid, rsp_result, rsp_inf, rsp_zero
  );
endinterface

// File: rtl/posit_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency posit adder among NREQ
// requesters; a tag shift register routes each result to its owner.
module posit_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  posit_add_arbiter_if.slave bus,
  output logic [3:0] inflight,
  output logic       idle,
  output logic       err_sync
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic          v;
    logic [PW-1:0] id;
  } tag_t;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gnt_id;
  logic               gnt_any;
  logic [NREQ-1:0]    gnt;
  logic [PW-1:0]      idx;

  logic               add_start_q, add_start_d;
  logic [31:0]        add_in1_q, add_in1_d;
  logic [31:0]        add_in2_q, add_in2_d;
  logic [PW-1:0]      id_q, id_d;

  tag_t [LATENCY-1:0] tag_q;
  tag_t               tag_in;
  tag_t               tag_out;

  logic [3:0]         inflight_q, inflight_d;
  logic [CW-1:0]      mask_q, mask_d;
  logic               err_q, err_d;
  logic               rsp_fire;

  // Search from ptr; the first valid requester wins.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (bus.hold || !rst_n) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) begin
      gnt = NREQ'(1) << gnt_id;
    end
  end

  assign bus.req_ready = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + PW'(1);
    end
  end

  always_comb begin
    add_start_d = gnt_any;
    add_in1_d   = '0;
    add_in2_d   = '0;
    id_d        = '0;
    if (gnt_any) begin
      add_in1_d = bus.req_in1[32*int'(gnt_id) +: 32];
      add_in2_d = bus.req_in2[32*int'(gnt_id) +: 32];
      id_d      = gnt_id;
    end
  end

  always_comb begin
    tag_in.v  = add_start_q;
    tag_in.id = add_start_q ? id_q : '0;
  end

  assign tag_out  = tag_q[LATENCY-1];
  assign rsp_fire = tag_out.v;

  always_comb begin
    bus.rsp_valid = '0;
    if (rsp_fire) begin
      bus.rsp_valid = NREQ'(1) << tag_out.id;
    end
  end

  assign bus.rsp_result = bus.add_result;
  assign bus.rsp_inf    = bus.add_inf;
  assign bus.rsp_zero   = bus.add_zero;

  assign bus.add_start = add_start_q;
  assign bus.add_in1   = add_in1_q;
  assign bus.add_in2   = add_in2_q;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({gnt_any, rsp_fire})
      2'b10: begin
        if (inflight_q != 4'hF) begin
          inflight_d = inflight_q + 4'd1;
        end
      end
      2'b01: begin
        if (inflight_q != 4'h0) begin
          inflight_d = inflight_q - 4'd1;
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  // The adder is not reset with us: ignore its done strobes until the
  // pre-reset contents have drained out.
  always_comb begin
    mask_d = mask_q;
    if (mask_q != '0) begin
      mask_d = mask_q - CW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (mask_q == '0 && (bus.add_done != tag_out.v)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      id_q        <= '0;
      inflight_q  <= '0;
      mask_q      <= CW'(LATENCY);
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      add_start_q <= add_start_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      id_q        <= id_d;
      inflight_q  <= inflight_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign inflight = inflight_q;
  assign idle     = bus.hold && (inflight_q == 4'd0);
  assign err_sync = err_q;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed bench for posit_add_arbiter with a fixed-latency adder stub.
// Table vectors cover arbitration; hand sequences cover multi-cycle cases.
module tb_posit_add_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] inflight;
  logic       idle;
  logic       err_sync;
  logic       force_done = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] in1 [NREQ];
  logic [31:0] in2 [NREQ];

  posit_add_arbiter_if #(.NREQ(NREQ)) bif ();

  posit_add_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif),
    .inflight (inflight),
    .idle     (idle),
    .err_sync (err_sync)
  );

  always #5 clk = ~clk;

  // Adder stub result: {zero, inf, value}
  function automatic logic [33:0] fadd(logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    if (a == 32'h8000_0000 || b == 32'h8000_0000) begin
      return {1'b0, 1'b1, 32'h8000_0000};
    end
    if (a == 32'h4000_0000 && b == 32'h4000_0000) begin
      return {1'b0, 1'b0, 32'h4800_0000};
    end
    r = a + b;
    return {(r == 32'h0), 1'b0, r};
  endfunction

  logic [33:0]    pipe_r [LAT];
  logic [LAT-1:0] pipe_v = '0;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], bif.add_start};
    pipe_r[0] <= fadd(bif.add_in1, bif.add_in2);
    for (int k = 1; k < LAT; k++) begin
      pipe_r[k] <= pipe_r[k-1];
    end
  end

  assign bif.add_done   = pipe_v[LAT-1] | force_done;
  assign bif.add_result = pipe_r[LAT-1][31:0];
  assign bif.add_inf    = pipe_r[LAT-1][32];
  assign bif.add_zero   = pipe_r[LAT-1][33];

  typedef struct {
    logic [3:0] rv;
    logic       hold;
    logic [3:0] rdy;
    logic [3:0] rsp;
    logic [3:0] infl;
    logic       idl;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bif.req_in1[32*i +: 32] = in1[i];
      bif.req_in2[32*i +: 32] = in2[i];
    end
  endtask

  task automatic default_ops();
    for (int i = 0; i < NREQ; i++) begin
      in1[i] = 32'h0100_0000 * (i + 1);
      in2[i] = 32'h0000_0010 * (i + 1);
    end
    drive_ops();
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after release.
  task automatic do_reset();
    bif.req_valid = 4'b1111;
    bif.hold      = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bif.req_ready), 32'h0);
    chk("rst_start", 32'(bif.add_start), 32'h0);
    chk("rst_in1", bif.add_in1, 32'h0);
    chk("rst_rsp", 32'(bif.rsp_valid), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_err", 32'(err_sync), 32'h0);
    cyc();
    rst_n         = 1'b1;
    bif.req_valid = '0;
  endtask

  task automatic chk_result(input string name, input logic [3:0] rsp);
    for (int i = 0; i < NREQ; i++) begin
      if (rsp[i]) begin
        chk(name, bif.rsp_result, fadd(in1[i], in2[i])[31:0]);
      end
    end
  endtask

  initial begin
    tv[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'd0, 1'b0};
    tv[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0};
    tv[2]  = '{4'b1010, 1'b0, 4'b0010, 4'b0000, 4'd1, 1'b0};
    tv[3]  = '{4'b1010, 1'b0, 4'b1000, 4'b0000, 4'd2, 1'b0};
    tv[4]  = '{4'b1010, 1'b0, 4'b0010, 4'b0000, 4'd3, 1'b0};
    tv[5]  = '{4'b0100, 1'b0, 4'b0100, 4'b0001, 4'd4, 1'b0};
    tv[6]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'd4, 1'b0};
    tv[7]  = '{4'b1111, 1'b1, 4'b0000, 4'b0010, 4'd5, 1'b0};
    tv[8]  = '{4'b1111, 1'b0, 4'b0010, 4'b1000, 4'd4, 1'b0};
    tv[9]  = '{4'b1111, 1'b0, 4'b0100, 4'b0010, 4'd4, 1'b0};
    tv[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 4'd4, 1'b0};
    tv[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 4'd3, 1'b0};
    tv[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'd2, 1'b0};
    tv[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 4'd2, 1'b0};
    tv[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 4'd1, 1'b0};
    tv[15] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b1};

    bif.req_valid = '0;
    bif.hold      = 1'b0;
    bif.req_in1   = '0;
    bif.req_in2   = '0;
    for (int k = 0; k < LAT; k++) begin
      pipe_r[k] = '0;
    end
    rst_n = 1'b0;
    default_ops();
    repeat (3) cyc();

    // Table: arbitration, hold, responses and occupancy
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bif.req_valid = tv[c].rv;
      bif.hold      = tv[c].hold;
      @(negedge clk);
      chk($sformatf("tv%0d_ready", c), 32'(bif.req_ready), 32'(tv[c].rdy));
      chk($sformatf("tv%0d_rsp", c), 32'(bif.rsp_valid), 32'(tv[c].rsp));
      chk($sformatf("tv%0d_infl", c), 32'(inflight), 32'(tv[c].infl));
      chk($sformatf("tv%0d_idle", c), 32'(idle), 32'(tv[c].idl));
      chk($sformatf("tv%0d_err", c), 32'(err_sync), 32'h0);
      chk_result($sformatf("tv%0d_res", c), tv[c].rsp);
      cyc();
    end
    bif.req_valid = '0;
    bif.hold      = 1'b0;

    // Single 1.0 + 1.0
    do_reset();
    in1[0] = 32'h4000_0000;
    in2[0] = 32'h4000_0000;
    drive_ops();
    bif.req_valid = 4'b0001;
    @(negedge clk);
    chk("one_ready", 32'(bif.req_ready), 32'h1);
    cyc();
    bif.req_valid = '0;
    @(negedge clk);
    chk("one_start", 32'(bif.add_start), 32'h1);
    chk("one_in1", bif.add_in1, 32'h4000_0000);
    chk("one_in2", bif.add_in2, 32'h4000_0000);
    cyc();
    @(negedge clk);
    chk("one_start_lo", 32'(bif.add_start), 32'h0);
    chk("one_in1_lo", bif.add_in1, 32'h0);
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) begin
        @(negedge clk);
      end
      chk($sformatf("one_rsp_t%0d", k), 32'(bif.rsp_valid),
          (k == 5) ? 32'h1 : 32'h0);
      if (k == 5) begin
        chk("one_result", bif.rsp_result, 32'h4800_0000);
        chk("one_inf", 32'(bif.rsp_inf), 32'h0);
      end
      cyc();
    end

    // NaR operand routed to requester 2
    do_reset();
    in1[2] = 32'h8000_0000;
    in2[2] = 32'h4000_0000;
    drive_ops();
    bif.req_valid = 4'b0100;
    @(negedge clk);
    chk("nar_ready", 32'(bif.req_ready), 32'h4);
    cyc();
    bif.req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("nar_rsp_t%0d", k), 32'(bif.rsp_valid),
          (k == 5) ? 32'h4 : 32'h0);
      if (k == 5) begin
        chk("nar_result", bif.rsp_result, 32'h8000_0000);
        chk("nar_inf", 32'(bif.rsp_inf), 32'h1);
        chk("nar_zero", 32'(bif.rsp_zero), 32'h0);
      end
      cyc();
    end

    // Fairness with everyone requesting for 8 cycles
    default_ops();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bif.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      chk($sformatf("rr%0d_ready", c), 32'(bif.req_ready),
          (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
      chk($sformatf("rr%0d_rsp", c), 32'(bif.rsp_valid),
          (c >= 5 && c < 13) ? (32'h1 << ((c - 5) % 4)) : 32'h0);
      chk($sformatf("rr%0d_infl", c), 32'(inflight),
          (c <= 5) ? 32'(c) : ((c <= 8) ? 32'd5 : 32'(13 - c)));
      chk_result($sformatf("rr%0d_res", c), bif.rsp_valid);
      cyc();
    end
    bif.req_valid = '0;

    // Hold from cycle 3 drains three operations
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bif.req_valid = 4'b1111;
      bif.hold      = (c >= 3);
      @(negedge clk);
      chk($sformatf("hd%0d_ready", c), 32'(bif.req_ready),
          (c < 3) ? (32'h1 << c) : 32'h0);
      chk($sformatf("hd%0d_rsp", c), 32'(bif.rsp_valid),
          (c >= 5 && c < 8) ? (32'h1 << (c - 5)) : 32'h0);
      chk($sformatf("hd%0d_idle", c), 32'(idle), (c >= 8) ? 32'h1 : 32'h0);
      cyc();
    end
    bif.req_valid = '0;
    bif.hold      = 1'b0;

    // Reset with three operations in flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bif.req_valid = 4'b1111;
      @(negedge clk);
      chk($sformatf("mf%0d_ready", c), 32'(bif.req_ready), 32'h1 << c);
      cyc();
    end
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("mf_post%0d_rsp", c), 32'(bif.rsp_valid), 32'h0);
      chk($sformatf("mf_post%0d_infl", c), 32'(inflight), 32'h0);
      chk($sformatf("mf_post%0d_err", c), 32'(err_sync), 32'h0);
      cyc();
    end
    bif.req_valid = 4'b1111;
    @(negedge clk);
    chk("mf_ptr0", 32'(bif.req_ready), 32'h1);
    cyc();
    bif.req_valid = '0;
    repeat (8) cyc();

    // Spurious done from the adder
    @(negedge clk);
    chk("mm_err_before", 32'(err_sync), 32'h0);
    cyc();
    force_done = 1'b1;
    @(negedge clk);
    chk("mm_rsp", 32'(bif.rsp_valid), 32'h0);
    cyc();
    force_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mm_err%0d", k), 32'(err_sync), 32'h1);
      chk($sformatf("mm_rsp%0d", k), 32'(bif.rsp_valid), 32'h0);
      cyc();
    end
    do_reset();
    @(negedge clk);
    chk("mm_err_cleared", 32'(err_sync), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
